// File: rtl/inst_encode.sv
// Packs decoded fields back into RV32I words into a 2-entry FIFO; accept-to-head latency 1 cycle.
// IN_READY depends only on registered occupancy, so there is no path from OUT_READY; unencodable fields yield a NOP with OUT_ERR set.
module inst_encode #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [31:0]          IN_PC,
  input  logic [16:0]          IN_OPCODE,
  input  logic [4:0]           IN_RD,
  input  logic [4:0]           IN_RS1,
  input  logic [4:0]           IN_RS2,
  input  logic [31:0]          IN_IMM,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_PC,
  output logic [31:0]          OUT_INST,
  output logic                 OUT_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [6:0]  op;
  logic [31:0] imm;
  logic [31:0] enc_raw;
  logic [31:0] enc_inst;
  logic        enc_err;

  logic [31:0]          pc_q   [2];
  logic [31:0]          inst_q [2];
  logic                 err_q  [2];
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [1:0]           cnt_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 push;
  logic                 pop;

  assign f7  = IN_OPCODE[16:10];
  assign f3  = IN_OPCODE[9:7];
  assign op  = IN_OPCODE[6:0];
  assign imm = IN_IMM;

  always_comb begin
    enc_raw = NOP;
    enc_err = 1'b0;
    case (op)
      7'b0110011: enc_raw = {f7, IN_RS2, IN_RS1, f3, IN_RD, op};
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        enc_raw = {imm[11:0], IN_RS1, f3, IN_RD, op};
        enc_err = |imm[31:12];
      end
      7'b0100011: begin
        enc_raw = {imm[11:5], IN_RS2, IN_RS1, f3, imm[4:0], op};
        enc_err = |imm[31:12];
      end
      7'b1100011: begin
        enc_raw = {imm[12], imm[10:5], IN_RS2, IN_RS1, f3, imm[4:1], imm[11], op};
        enc_err = (|imm[31:13]) | imm[0];
      end
      7'b0110111, 7'b0010111: begin
        enc_raw = {imm[31:12], IN_RD, op};
        enc_err = |imm[11:0];
      end
      7'b1101111: begin
        enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], IN_RD, op};
        enc_err = (|imm[31:21]) | imm[0];
      end
      default: enc_err = 1'b1;
    endcase
    enc_inst = enc_err ? NOP : enc_raw;
  end

  assign IN_READY  = (cnt_q != 2'd2);
  assign OUT_VALID = (cnt_q != 2'd0);
  assign push      = IN_VALID & IN_READY;
  assign pop       = OUT_VALID & OUT_READY;

  // Empty FIFO presents the idle pattern rather than stale storage.
  assign OUT_PC   = OUT_VALID ? pc_q[rd_ptr_q]   : 32'h0;
  assign OUT_INST = OUT_VALID ? inst_q[rd_ptr_q] : NOP;
  assign OUT_ERR  = OUT_VALID ? err_q[rd_ptr_q]  : 1'b0;
  assign ERR_CNT  = err_cnt_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 2; i++) begin
        pc_q[i]   <= 32'h0;
        inst_q[i] <= NOP;
        err_q[i]  <= 1'b0;
      end
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      err_cnt_q <= '0;
    end else if (FLUSH) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q]   <= IN_PC;
        inst_q[wr_ptr_q] <= enc_inst;
        err_q[wr_ptr_q]  <= enc_err;
        wr_ptr_q         <= ~wr_ptr_q;
        if (enc_err && !(&err_cnt_q))
          err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
      if (pop)
        rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encode.sv
module tb_inst_encode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST, FLUSH, IN_VALID, IN_READY, OUT_VALID, OUT_READY, OUT_ERR;
  logic [31:0] IN_PC, IN_IMM, OUT_PC, OUT_INST;
  logic [16:0] IN_OPCODE;
  logic [4:0]  IN_RD, IN_RS1, IN_RS2;
  logic [7:0]  ERR_CNT;

  inst_encode #(.ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_PC(IN_PC), .IN_OPCODE(IN_OPCODE), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2),
    .IN_IMM(IN_IMM), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_PC(OUT_PC),
    .OUT_INST(OUT_INST), .OUT_ERR(OUT_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [16:0] opc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  exp_t        cur_exp;
  int          total = 0;
  int          bad = 0;
  logic [7:0]  exp_cnt = 8'd0;
  logic [7:0]  snap_cnt;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic        pushed = 1'b0;

  function automatic logic [16:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, f3, op};
  endfunction

  function automatic vec_t v(input logic [16:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] inst,
                             input logic err);
    vec_t r;
    r.opc = opc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.inst = inst; r.err = err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard step, sampled on the falling edge while inputs are stable.
  task automatic mon();
    exp_t e;
    check("err_cnt_track", {24'h0, ERR_CNT}, {24'h0, exp_cnt});
    pushed = 1'b0;
    if (!RST) begin
      sbq.delete();
      exp_cnt = 8'd0;
    end else if (FLUSH) begin
      sbq.delete();
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (sbq.size() == 0) begin
          check("unexpected_out", {31'h0, OUT_VALID}, 32'h0);
        end else begin
          e = sbq.pop_front();
          check("out_inst", OUT_INST, e.inst);
          check("out_err", {31'h0, OUT_ERR}, {31'h0, e.err});
          check("out_pc", OUT_PC, e.pc);
        end
      end
      if (IN_VALID && IN_READY) begin
        sbq.push_back(cur_exp);
        pushed = 1'b1;
        if (cur_exp.err && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    mon();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input vec_t x);
    IN_OPCODE = x.opc; IN_RD = x.rd; IN_RS1 = x.rs1; IN_RS2 = x.rs2; IN_IMM = x.imm;
    IN_PC = pc_ctr;
    cur_exp.pc = pc_ctr; cur_exp.inst = x.inst; cur_exp.err = x.err;
    pc_ctr = pc_ctr + 32'd4;
    IN_VALID = 1'b1;
  endtask

  task automatic send(input vec_t x, input bit rnd);
    logic got = 1'b0;
    drive(x);
    for (int k = 0; k < 40; k++) begin
      if (rnd) OUT_READY = 1'($urandom_range(0, 1));
      tick();
      if (pushed) begin
        got = 1'b1;
        break;
      end
    end
    IN_VALID = 1'b0;
    check("accept", {31'h0, got}, 32'h1);
  endtask

  task automatic drain();
    OUT_READY = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (sbq.size() == 0) break;
      tick();
    end
    check("drain", sbq.size(), 32'h0);
    check("empty_after_drain", {31'h0, OUT_VALID}, 32'h0);
  endtask

  initial begin
    vec_t addi, bad_op, beq7;
    addi   = v(mk(7'h00, 3'b000, 7'h13), 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 1'b0);
    bad_op = v(mk(7'h00, 3'b000, 7'h7F), 5'd1, 5'd2, 5'd3, 32'd0, NOP, 1'b1);
    beq7   = v(mk(7'h00, 3'b000, 7'h63), 5'd0, 5'd1, 5'd2, 32'd7, NOP, 1'b1);

    tbl.push_back(addi);
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h33), 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h63), 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h6F), 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h37), 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    tbl.push_back(v(mk(7'h20, 3'b000, 7'h33), 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0));
    tbl.push_back(v(mk(7'h7F, 3'b000, 7'h13), 5'd1, 5'd0, 5'd7, 32'd5, 32'h0050_0093, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b010, 7'h23), 5'd31, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b010, 7'h03), 5'd5, 5'd2, 5'd0, 32'd4, 32'h0041_2283, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h17), 5'd1, 5'd0, 5'd0, 32'h0000_1000, 32'h0000_1097, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h63), 5'd0, 5'd0, 5'd0, 32'h0000_1FFE, 32'hFE00_0FE3, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h73), 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0073, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h0F), 5'd0, 5'd0, 5'd0, 32'h0000_00FF, 32'h0FF0_000F, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h67), 5'd0, 5'd1, 5'd0, 32'd0, 32'h0000_8067, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h13), 5'd1, 5'd0, 5'd0, 32'h0000_0FFF, 32'hFFF0_0093, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h6F), 5'd0, 5'd0, 5'd0, 32'h001F_FFFE, 32'hFFFF_F06F, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h23), 5'd31, 5'd0, 5'd0, 32'h0000_0FFF, 32'hFE00_0FA3, 1'b0));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h13), 5'd1, 5'd0, 5'd0, 32'h0000_1000, NOP, 1'b1));
    tbl.push_back(v(mk(7'h00, 3'b010, 7'h23), 5'd0, 5'd1, 5'd2, 32'h0001_0000, NOP, 1'b1));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h63), 5'd0, 5'd1, 5'd2, 32'h0000_2000, NOP, 1'b1));
    tbl.push_back(beq7);
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h37), 5'd5, 5'd0, 5'd0, 32'h1234_5001, NOP, 1'b1));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h6F), 5'd1, 5'd0, 5'd0, 32'h0020_0000, NOP, 1'b1));
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h6F), 5'd1, 5'd0, 5'd0, 32'h0000_0011, NOP, 1'b1));
    tbl.push_back(bad_op);
    tbl.push_back(v(mk(7'h00, 3'b000, 7'h00), 5'd1, 5'd1, 5'd1, 32'd0, NOP, 1'b1));

    RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN_PC = 32'h0; IN_OPCODE = 17'h0; IN_RD = 5'd0; IN_RS1 = 5'd0; IN_RS2 = 5'd0; IN_IMM = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", {31'h0, OUT_VALID}, 32'h0);
    check("rst_out_pc", OUT_PC, 32'h0);
    check("rst_out_inst", OUT_INST, NOP);
    check("rst_out_err", {31'h0, OUT_ERR}, 32'h0);
    check("rst_err_cnt", {24'h0, ERR_CNT}, 32'h0);
    check("rst_in_ready", {31'h0, IN_READY}, 32'h1);
    RST = 1'b1;
    tick();

    // Two unencodable entries from a clean counter.
    OUT_READY = 1'b1;
    send(bad_op, 1'b0);
    send(beq7, 1'b0);
    drain();
    check("err_pair_cnt", {24'h0, ERR_CNT}, 32'd2);

    // Single-cycle latency into an empty FIFO.
    OUT_READY = 1'b0;
    send(addi, 1'b0);
    check("lat_valid", {31'h0, OUT_VALID}, 32'h1);
    check("lat_inst", OUT_INST, 32'h0050_0093);
    check("lat_err", {31'h0, OUT_ERR}, 32'h0);
    drain();

    OUT_READY = 1'b1;
    foreach (tbl[i]) send(tbl[i], 1'b0);
    drain();
    foreach (tbl[i]) send(tbl[i], 1'b1);
    drain();

    // Backpressure: third entry waits until the head is taken.
    OUT_READY = 1'b0;
    send(tbl[1], 1'b0);
    send(tbl[2], 1'b0);
    check("full_in_ready", {31'h0, IN_READY}, 32'h0);
    drive(tbl[3]);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_no_accept", {31'h0, pushed}, 32'h0);
      check("bp_head_stable", OUT_INST, tbl[1].inst);
      check("bp_head_valid", {31'h0, OUT_VALID}, 32'h1);
    end
    OUT_READY = 1'b1;
    begin
      logic got = 1'b0;
      for (int k = 0; k < 10; k++) begin
        tick();
        if (pushed) begin
          got = 1'b1;
          break;
        end
      end
      check("bp_third_accept", {31'h0, got}, 32'h1);
    end
    IN_VALID = 1'b0;
    drain();

    // Flush a full FIFO while an erroneous push is offered.
    OUT_READY = 1'b0;
    send(tbl[0], 1'b0);
    send(tbl[4], 1'b0);
    snap_cnt = exp_cnt;
    drive(bad_op);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    IN_VALID = 1'b0;
    check("flush_valid", {31'h0, OUT_VALID}, 32'h0);
    check("flush_inst", OUT_INST, NOP);
    check("flush_in_ready", {31'h0, IN_READY}, 32'h1);
    check("flush_err_cnt", {24'h0, ERR_CNT}, {24'h0, snap_cnt});
    OUT_READY = 1'b1;
    repeat (3) tick();
    send(addi, 1'b0);
    drain();

    // Counter saturation.
    OUT_READY = 1'b1;
    for (int k = 0; k < 260; k++) send(bad_op, 1'b0);
    drain();
    check("sat_err_cnt", {24'h0, ERR_CNT}, 32'h0000_00FF);

    // Reset with one entry buffered.
    OUT_READY = 1'b0;
    send(tbl[1], 1'b0);
    RST = 1'b0;
    tick();
    check("mrst_valid", {31'h0, OUT_VALID}, 32'h0);
    check("mrst_inst", OUT_INST, NOP);
    check("mrst_pc", OUT_PC, 32'h0);
    check("mrst_err_cnt", {24'h0, ERR_CNT}, 32'h0);
    RST = 1'b1;
    tick();
    check("mrst_in_ready", {31'h0, IN_READY}, 32'h1);
    send(addi, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
